// File: rtl/conv_window_mac_if.sv
// Handshake bundle for conv_window_mac: window/kernel/bias loads in, MAC results out.
interface conv_window_mac_if #(
  parameter int KERNEL_SIZE = 3,
  parameter int DATA_SIZE   = 8,
  parameter int WEIGHT_SIZE = 8,
  parameter int ACC_SIZE    = 24
);
  logic                                          data_valid;
  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_SIZE-1:0]  window_in;
  logic                                          weight_valid;
  logic [WEIGHT_SIZE-1:0]                        weight_in;
  logic                                          bias_valid;
  logic [ACC_SIZE-1:0]                           bias_in;
  logic                                          conv_valid;
  logic [ACC_SIZE-1:0]                           conv_out;
  logic                                          frame_done;

  modport master (
    output data_valid, window_in, weight_valid, weight_in, bias_valid, bias_in,
    input  conv_valid, conv_out, frame_done
  );

  modport slave (
    input  data_valid, window_in, weight_valid, weight_in, bias_valid, bias_in,
    output conv_valid, conv_out, frame_done
  );
endinterface

// File: rtl/conv_window_mac.sv
// KxK window multiply-accumulate with in-image window qualification, serial kernel/bias load,
// optional ReLU and a fixed 3-stage pipeline.
module conv_window_mac #(
  parameter int KERNEL_SIZE = 3,
  parameter int DATA_SIZE   = 8,
  parameter int WEIGHT_SIZE = 8,
  parameter int ROW_SIZE    = 28,
  parameter int IMG_ROWS    = 28,
  parameter int ACC_SIZE    = 24,
  parameter bit RELU_EN     = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  conv_window_mac_if.slave bus
);
  localparam int KK     = KERNEL_SIZE * KERNEL_SIZE;
  localparam int PW     = DATA_SIZE + WEIGHT_SIZE + 1;
  localparam int STAGES = 3;
  localparam int CW     = $clog2(ROW_SIZE);
  localparam int RW     = $clog2(IMG_ROWS);

  logic [CW-1:0]                 r_col;
  logic [RW-1:0]                 r_row;
  logic signed [WEIGHT_SIZE-1:0] r_w [KK];
  logic signed [ACC_SIZE-1:0]    r_bias;
  logic signed [PW-1:0]          r_prod [KK];
  logic signed [PW-1:0]          w_prod [KK];
  logic signed [ACC_SIZE-1:0]    r_sum, w_sum, w_res, w_relu, r_out;
  logic [STAGES:1]               r_vld_pipe, r_last_pipe;
  logic                          w_col_end, w_row_end, w_keep;

  assign w_col_end = (r_col == CW'(ROW_SIZE - 1));
  assign w_row_end = (r_row == RW'(IMG_ROWS - 1));
  // Counters are pre-increment here, so the window is judged at its newest pixel.
  assign w_keep    = bus.data_valid && (r_col >= CW'(KERNEL_SIZE - 1)) &&
                     (r_row >= RW'(KERNEL_SIZE - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_col <= '0;
      r_row <= '0;
    end else if (bus.data_valid) begin
      if (w_col_end) begin
        r_col <= '0;
        r_row <= w_row_end ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  // Kernel shifts toward index 0, so the first-written coefficient ends at index 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < KK; i++) r_w[i] <= '0;
      r_bias <= '0;
    end else begin
      if (bus.weight_valid) begin
        for (int i = 0; i < KK - 1; i++) r_w[i] <= r_w[i+1];
        r_w[KK-1] <= bus.weight_in;
      end
      if (bus.bias_valid) r_bias <= bus.bias_in;
    end
  end

  for (genvar i = 0; i < KK; i++) begin : g_lane
    logic signed [PW-1:0] w_px, w_wt;
    assign w_px      = {{(PW - DATA_SIZE){1'b0}}, bus.window_in[i*DATA_SIZE +: DATA_SIZE]};
    assign w_wt      = {{(PW - WEIGHT_SIZE){r_w[i][WEIGHT_SIZE-1]}}, r_w[i]};
    assign w_prod[i] = w_px * w_wt;
  end

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < KK; i++)
      w_sum = w_sum + {{(ACC_SIZE - PW){r_prod[i][PW-1]}}, r_prod[i]};
  end

  assign w_res  = r_sum + r_bias;
  assign w_relu = (RELU_EN && w_res[ACC_SIZE-1]) ? '0 : w_res;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < KK; i++) r_prod[i] <= '0;
      r_sum       <= '0;
      r_out       <= '0;
      r_vld_pipe  <= '0;
      r_last_pipe <= '0;
    end else begin
      if (w_keep) for (int i = 0; i < KK; i++) r_prod[i] <= w_prod[i];
      if (r_vld_pipe[1]) r_sum <= w_sum;
      if (r_vld_pipe[2]) r_out <= w_relu;
      r_vld_pipe  <= {r_vld_pipe[STAGES-1:1], w_keep};
      r_last_pipe <= {r_last_pipe[STAGES-1:1], w_keep & w_col_end & w_row_end};
    end
  end

  assign bus.conv_valid = r_vld_pipe[STAGES];
  assign bus.conv_out   = r_out;
  assign bus.frame_done = r_last_pipe[STAGES];
endmodule
